spi_fifo: RTL and testbench

- Synchronous single-clock FIFO buffering 16-bit words for the SPI peripheral data path.
- The producer pushes with `wen`; the consumer pops with `ren`.
- Read data is first-word-fall-through: `rdata` always shows the head word.
- Provides full/empty status and a synchronous flush input (`shiftFIFO`) that discards all stored words.

---
 rtl/spi_fifo_if.sv | 33 +++
 rtl/spi_fifo.sv | 79 +++++++
 tb/tb_spi_fifo.sv | 131 +++++++++++++
 3 files changed

// File: rtl/spi_fifo_if.sv
// Handshake and data bundle between the SPI data path and its 16-bit word FIFO.
// The master side produces pushes/pops/flush; the slave side is the FIFO itself.
interface spi_fifo_if #(
  parameter int WIDTH = 16
);
  logic             wen;
  logic [WIDTH-1:0] wdata;
  logic             ren;
  logic [WIDTH-1:0] rdata;
  logic             full;
  logic             empty;
  logic             shiftFIFO;

  modport master (
    output wen,
    output wdata,
    output ren,
    output shiftFIFO,
    input  rdata,
    input  full,
    input  empty
  );

  modport slave (
    input  wen,
    input  wdata,
    input  ren,
    input  shiftFIFO,
    output rdata,
    output full,
    output empty
  );
endinterface

// File: rtl/spi_fifo.sv
// Single-clock first-word-fall-through FIFO for SPI words, with full/empty
// status derived from an occupancy counter and a synchronous flush.
module spi_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input logic        clk,
  input logic        rstn,
  spi_fifo_if.slave  bus
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             is_full;
  logic             is_empty;
  logic             rd_acc;
  logic             wr_acc;

  assign is_full  = (count_q == CNT_FULL);
  assign is_empty = (count_q == '0);

  // A write into a full FIFO is still accepted when a pop frees a slot on the same edge.
  assign rd_acc = bus.ren && !is_empty && !bus.shiftFIFO;
  assign wr_acc = bus.wen && (!is_full || (bus.ren && !is_empty)) && !bus.shiftFIFO;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.shiftFIFO) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (wr_acc) mem_d[wr_ptr_q] = bus.wdata;
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; the counter alone decides which words are valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.full  = is_full;
  assign bus.empty = is_empty;
  assign bus.rdata = is_empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_spi_fifo.sv
// Directed plus randomized bench for spi_fifo, checked against a queue model
// of the FIFO's observable behaviour.
module tb_spi_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  spi_fifo_if #(.WIDTH(WIDTH)) bus ();

  spi_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  logic [WIDTH-1:0] model [$];
  int checkCount = 0;
  int passCount  = 0;

  task automatic checkOutput(input string tag);
    logic [WIDTH-1:0] expData;
    logic             expFull;
    logic             expEmpty;
    expData  = (model.size() != 0) ? model[0] : '0;
    expFull  = (model.size() == DEPTH);
    expEmpty = (model.size() == 0);
    checkCount++;
    assert (bus.rdata === expData) passCount++;
    else $error("[TB] FAIL %s rdata got %h want %h", tag, bus.rdata, expData);
    checkCount++;
    assert (bus.full === expFull) passCount++;
    else $error("[TB] FAIL %s full got %b want %b", tag, bus.full, expFull);
    checkCount++;
    assert (bus.empty === expEmpty) passCount++;
    else $error("[TB] FAIL %s empty got %b want %b", tag, bus.empty, expEmpty);
  endtask

  // Drives one clock of inputs from a falling edge and checks at the next falling edge.
  task automatic applyStimulus(input logic w, input logic [WIDTH-1:0] d,
                               input logic r, input logic f, input string tag);
    bit rdAcc;
    bit wrAcc;
    bus.wen       = w;
    bus.wdata     = d;
    bus.ren       = r;
    bus.shiftFIFO = f;
    @(posedge clk);
    if (f) begin
      model.delete();
    end else begin
      rdAcc = r && (model.size() != 0);
      wrAcc = w && ((model.size() < DEPTH) || rdAcc);
      if (rdAcc) void'(model.pop_front());
      if (wrAcc) model.push_back(d);
    end
    @(negedge clk);
    bus.wen       = 1'b0;
    bus.ren       = 1'b0;
    bus.shiftFIFO = 1'b0;
    checkOutput(tag);
  endtask

  logic [WIDTH-1:0] seqA [4]  = '{16'hFFFF, 16'h00FF, 16'h1111, 16'hB232};
  logic [WIDTH-1:0] seqB [8]  = '{16'hFFFF, 16'h00FF, 16'h1111, 16'hB232,
                                  16'hCFFF, 16'hE0FF, 16'hAAAA, 16'hBBBB};

  initial begin
    bus.wen       = 1'b0;
    bus.wdata     = '0;
    bus.ren       = 1'b0;
    bus.shiftFIFO = 1'b0;
    rstn          = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset");
    rstn = 1'b0;
    @(negedge clk);
    checkOutput("post_reset");

    for (int i = 0; i < 4; i++) applyStimulus(1'b1, seqA[i], 1'b0, 1'b0, "fill4");
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, "read2");

    for (int i = 0; i < 8; i++) applyStimulus(1'b1, seqB[i], 1'b0, 1'b0, "fill_full");
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, "drain12");

    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 16'h0017, 1'b0, 1'b0, "w0017");
    applyStimulus(1'b1, 16'h5555, 1'b1, 1'b1, "flush");
    applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0, "w1234");
    applyStimulus(1'b0, '0, 1'b1, 1'b0, "r1234");

    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b1, WIDTH'($urandom), 1'b0, 1'b0, "fill_rand");
    applyStimulus(1'b1, 16'hC0DE, 1'b1, 1'b0, "rw_full");
    applyStimulus(1'b1, 16'hBEEF, 1'b1, 1'b0, "rw_full2");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, "drain_rw");
    applyStimulus(1'b1, 16'h7777, 1'b1, 1'b0, "rw_empty");
    applyStimulus(1'b0, '0, 1'b1, 1'b0, "r7777");

    for (int i = 0; i < 400; i++) begin
      logic w, r, f;
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 45);
      f = ($urandom_range(0, 99) < 3);
      applyStimulus(w, WIDTH'($urandom), r, f, "random");
    end

    applyStimulus(1'b1, '0, 1'b0, 1'b1, "pre_async_flush");
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, WIDTH'($urandom), 1'b0, 1'b0, "fill5");
    #2;
    rstn = 1'b1;
    #1;
    model.delete();
    checkOutput("async_reset");
    @(negedge clk);
    rstn = 1'b0;
    applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0, "after_reset_w");
    applyStimulus(1'b0, '0, 1'b1, 1'b0, "after_reset_r");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
